// File: rtl/ccip_tx_buf_pkg.sv
// Shared defaults and statistics payload for the per-channel CCI-P Tx request buffers.
package ccip_tx_buf_pkg;

   // C0 (read request) channel buffer geometry
   localparam int unsigned C0_DATA_W = 550;
   localparam int unsigned C0_DEPTH  = 64;
   localparam int unsigned C0_SKID   = 8;

   // C1 (write request) channel buffer geometry
   localparam int unsigned C1_DATA_W = 550;
   localparam int unsigned C1_DEPTH  = 64;
   localparam int unsigned C1_SKID   = 8;

   // Statistics field widths; both channels share the same depth
   localparam int unsigned STAT_CNT_W = 16;
   localparam int unsigned STAT_OCC_W = $clog2(C0_DEPTH) + 1;

   typedef struct packed {
      logic [STAT_OCC_W-1:0] occupancy;
      logic [STAT_OCC_W-1:0] max_occ;
      logic [STAT_CNT_W-1:0] drop_cnt;
      logic                  overflow;
   } t_buf_stat;

endpackage

// File: rtl/ccip_tx_buf_ram.sv
// Simple dual-port storage for the Tx request buffer: one write port, one registered read port.
module ccip_tx_buf_ram #(
   parameter int unsigned DATA_W = 550,
   parameter int unsigned DEPTH  = 64,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; the array itself is never reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read returns the pre-write contents on an address collision,
   // which is what a full FIFO doing push+pop needs (head leaves, tail lands)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/ccip_tx_almfull_buf.sv
// Per-channel CCI-P Tx skid buffer: absorbs AFU requests issued after almost-full,
// drains only while the platform almost-full is low, and keeps occupancy/drop stats.
module ccip_tx_almfull_buf
   import ccip_tx_buf_pkg::*;
#(
   parameter int unsigned DATA_W = C0_DATA_W,
   parameter int unsigned DEPTH  = C0_DEPTH,
   parameter int unsigned SKID   = C0_SKID,
   parameter int unsigned CNT_W  = STAT_CNT_W,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned OCC_W = PTR_W + 1
) (
   input  logic              pClk,
   input  logic              pck_cp2af_softReset_n,
   input  logic              afu_valid,
   input  logic [DATA_W-1:0] afu_data,
   output logic              buf_almfull,
   input  logic              cp_almfull,
   output logic              cp_valid,
   output logic [DATA_W-1:0] cp_data,
   input  logic              stat_clr,
   output logic [OCC_W-1:0]  occupancy,
   output logic [OCC_W-1:0]  max_occ,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic              overflow
);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] occ_nxt;
   logic [CNT_W-1:0] drop_q;
   logic             full_c;
   logic             pop_c;
   logic             push_c;
   logic             drop_c;
   t_buf_stat        stat_q;

   assign occ    = OCC_W'(stat_q.occupancy);
   assign drop_q = CNT_W'(stat_q.drop_cnt);

   // Push/pop decisions; a pop frees a slot for a push on the same edge
   always_comb begin
      full_c  = 1'b0;
      pop_c   = 1'b0;
      push_c  = 1'b0;
      drop_c  = 1'b0;
      occ_nxt = occ;
      full_c  = (occ == OCC_W'(DEPTH));
      pop_c   = !cp_almfull && (occ != '0);
      push_c  = afu_valid && (!full_c || pop_c);
      drop_c  = afu_valid && full_c && !pop_c;
      if (push_c && !pop_c)      occ_nxt = occ + OCC_W'(1);
      else if (pop_c && !push_c) occ_nxt = occ - OCC_W'(1);
   end

   // Pointers, output valid pulse and early almost-full toward the AFU
   always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
      if (!pck_cp2af_softReset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cp_valid    <= 1'b0;
         buf_almfull <= 1'b1;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         cp_valid    <= pop_c;
         buf_almfull <= (occ_nxt >= OCC_W'(DEPTH - SKID));
      end
   end

   // Occupancy and statistics; a clear overrides a same-cycle drop
   always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
      if (!pck_cp2af_softReset_n) begin
         stat_q <= '0;
      end else begin
         stat_q.occupancy <= STAT_OCC_W'(occ_nxt);
         if (stat_clr) begin
            stat_q.max_occ  <= STAT_OCC_W'(occ_nxt);
            stat_q.drop_cnt <= '0;
            stat_q.overflow <= 1'b0;
         end else begin
            if (occ_nxt > OCC_W'(stat_q.max_occ)) stat_q.max_occ <= STAT_OCC_W'(occ_nxt);
            if (drop_c) begin
               stat_q.overflow <= 1'b1;
               if (drop_q != '1) stat_q.drop_cnt <= STAT_CNT_W'(drop_q + CNT_W'(1));
            end
         end
      end
   end

   assign occupancy = occ;
   assign max_occ   = OCC_W'(stat_q.max_occ);
   assign drop_cnt  = drop_q;
   assign overflow  = stat_q.overflow;

   ccip_tx_buf_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (pClk),
      .rst_n   (pck_cp2af_softReset_n),
      .wr_en   (push_c),
      .wr_addr (wr_ptr),
      .wr_data (afu_data),
      .rd_en   (pop_c),
      .rd_addr (rd_ptr),
      .rd_data (cp_data)
   );

endmodule

// File: tb/tb_ccip_tx_almfull_buf.sv
// Bench for ccip_tx_almfull_buf: queue-based reference model, table vectors,
// directed corner sequences and randomized traffic.
module tb_ccip_tx_almfull_buf;

   localparam int unsigned DATA_W = 550;
   localparam int unsigned DEPTH  = 64;
   localparam int unsigned SKID   = 8;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned OCC_W  = 7;

   logic              pClk;
   logic              rst_n;
   logic              afu_valid;
   logic [DATA_W-1:0] afu_data;
   logic              buf_almfull;
   logic              cp_almfull;
   logic              cp_valid;
   logic [DATA_W-1:0] cp_data;
   logic              stat_clr;
   logic [OCC_W-1:0]  occupancy;
   logic [OCC_W-1:0]  max_occ;
   logic [CNT_W-1:0]  drop_cnt;
   logic              overflow;

   ccip_tx_almfull_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .SKID   (SKID),
      .CNT_W  (CNT_W)
   ) dut (
      .pClk                  (pClk),
      .pck_cp2af_softReset_n (rst_n),
      .afu_valid             (afu_valid),
      .afu_data              (afu_data),
      .buf_almfull           (buf_almfull),
      .cp_almfull            (cp_almfull),
      .cp_valid              (cp_valid),
      .cp_data               (cp_data),
      .stat_clr              (stat_clr),
      .occupancy             (occupancy),
      .max_occ               (max_occ),
      .drop_cnt              (drop_cnt),
      .overflow              (overflow)
   );

   initial pClk = 1'b0;
   always #5 pClk = ~pClk;

   int n_pass;
   int n_total;
   int dut_pulses;

   // Reference model: a queue of accepted payloads plus plain statistics
   logic [DATA_W-1:0] mq[$];
   logic [DATA_W-1:0] m_data;
   bit                m_valid;
   bit                m_almfull;
   bit                m_ovf;
   int                m_max;
   int                m_drop;

   typedef struct {
      bit v;
      bit alm;
      bit clr;
      bit exp_valid;
      int exp_occ;
      bit exp_almf;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
   endtask

   task automatic chk_data(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
   endtask

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      d = '0;
      for (int i = 0; i < 18; i++) d = {d[DATA_W-33:0], 32'($urandom())};
      return d;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_data    = '0;
      m_valid   = 1'b0;
      m_almfull = 1'b1;
      m_ovf     = 1'b0;
      m_max     = 0;
      m_drop    = 0;
   endtask

   // One clock edge of the buffer's contract: pop the head if allowed, then
   // accept the push if there is room left, otherwise count a drop.
   task automatic model_step();
      bit pop;
      bit dropped;
      pop     = !cp_almfull && (mq.size() > 0);
      dropped = 1'b0;
      m_valid = pop;
      if (pop) m_data = mq.pop_front();
      if (afu_valid) begin
         if (mq.size() < DEPTH) mq.push_back(afu_data);
         else dropped = 1'b1;
      end
      if (stat_clr) begin
         m_ovf  = 1'b0;
         m_drop = 0;
         m_max  = mq.size();
      end else begin
         if (mq.size() > m_max) m_max = mq.size();
         if (dropped) begin
            m_ovf = 1'b1;
            if (m_drop < (1 << CNT_W) - 1) m_drop++;
         end
      end
      m_almfull = (mq.size() >= DEPTH - SKID);
   endtask

   task automatic check_all();
      chk("cp_valid", 64'(cp_valid), 64'(m_valid));
      chk_data("cp_data", cp_data, m_data);
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("buf_almfull", 64'(buf_almfull), 64'(m_almfull));
      chk("max_occ", 64'(max_occ), 64'(m_max));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("overflow", 64'(overflow), 64'(m_ovf));
   endtask

   // Inputs are set while the clock is low; outputs are sampled 1 time unit after the edge
   task automatic cycle();
      @(posedge pClk);
      model_step();
      #1;
      check_all();
      if (cp_valid) dut_pulses++;
      @(negedge pClk);
   endtask

   task automatic drive(input bit v, input bit alm, input bit clr);
      afu_valid  = v;
      afu_data   = rand_data();
      cp_almfull = alm;
      stat_clr   = clr;
   endtask

   initial begin
      int p_v;
      int p_alm;

      n_pass     = 0;
      n_total    = 0;
      dut_pulses = 0;

      // hand-computed vectors applied from an empty buffer: v, alm, clr -> valid, occ, almfull
      vecs[0] = '{1, 1, 0, 0, 1, 0};
      vecs[1] = '{1, 1, 0, 0, 2, 0};
      vecs[2] = '{0, 0, 0, 1, 1, 0};
      vecs[3] = '{1, 0, 0, 1, 1, 0};
      vecs[4] = '{0, 0, 0, 1, 0, 0};
      vecs[5] = '{0, 0, 0, 0, 0, 0};
      vecs[6] = '{1, 0, 0, 0, 1, 0};
      vecs[7] = '{0, 0, 0, 1, 0, 0};
      vecs[8] = '{1, 1, 1, 0, 1, 0};
      vecs[9] = '{0, 0, 0, 1, 0, 0};

      rst_n      = 1'b0;
      afu_valid  = 1'b0;
      afu_data   = '0;
      cp_almfull = 1'b0;
      stat_clr   = 1'b0;
      model_reset();

      // Reset state
      #12;
      chk("rst_buf_almfull", 64'(buf_almfull), 64'd1);
      chk("rst_cp_valid", 64'(cp_valid), 64'd0);
      chk_data("rst_cp_data", cp_data, '0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_max_occ", 64'(max_occ), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      @(negedge pClk);
      rst_n = 1'b1;
      drive(0, 0, 0);
      cycle();
      chk("almfull_after_release", 64'(buf_almfull), 64'd0);

      // Table vectors
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].v, vecs[i].alm, vecs[i].clr);
         cycle();
         chk($sformatf("vec%0d_valid", i), 64'(cp_valid), 64'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(vecs[i].exp_occ));
         chk($sformatf("vec%0d_almf", i), 64'(buf_almfull), 64'(vecs[i].exp_almf));
      end

      // Streaming with platform open: one-cycle latency, occupancy never above 1
      drive(0, 0, 1);
      cycle();
      for (int i = 0; i < 100; i++) begin
         drive(1, 0, 0);
         cycle();
      end
      chk("stream_max_occ", 64'(max_occ), 64'd1);
      drive(0, 0, 0);
      cycle();

      // Fill behind a closed platform: almost-full threshold then full without loss
      for (int i = 1; i <= 64; i++) begin
         drive(1, 1, 0);
         cycle();
         if (i == 55) chk("almf_at_55", 64'(buf_almfull), 64'd0);
         if (i == 56) chk("almf_at_56", 64'(buf_almfull), 64'd1);
      end
      chk("fill_occ", 64'(occupancy), 64'd64);
      chk("fill_overflow", 64'(overflow), 64'd0);
      dut_pulses = 0;
      for (int i = 0; i < 70; i++) begin
         drive(0, 0, 0);
         cycle();
      end
      chk("drain_pulses", 64'(dut_pulses), 64'd64);

      // Overflow on a full, blocked buffer, then statistics clear
      for (int i = 0; i < 64; i++) begin
         drive(1, 1, 0);
         cycle();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0);
         cycle();
      end
      chk("ovf_drop_cnt", 64'(drop_cnt), 64'd3);
      chk("ovf_overflow", 64'(overflow), 64'd1);
      chk("ovf_occ", 64'(occupancy), 64'd64);
      drive(0, 1, 1);
      cycle();
      chk("clr_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("clr_overflow", 64'(overflow), 64'd0);
      chk("clr_max_occ", 64'(max_occ), 64'd64);
      // clear wins over a drop in the same cycle
      drive(1, 1, 1);
      cycle();
      chk("clrwin_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("clrwin_overflow", 64'(overflow), 64'd0);

      // Full buffer with platform open: push and pop together, nothing lost
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0);
         cycle();
         chk("fullpp_occ", 64'(occupancy), 64'd64);
         chk("fullpp_drop", 64'(drop_cnt), 64'd0);
      end
      for (int i = 0; i < 70; i++) begin
         drive(0, 0, 0);
         cycle();
      end

      // Reset with entries queued: outputs cleared at once, nothing stale afterwards
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 0);
         cycle();
      end
      drive(0, 0, 0);
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_cp_valid", 64'(cp_valid), 64'd0);
      chk("midrst_occ", 64'(occupancy), 64'd0);
      chk_data("midrst_cp_data", cp_data, '0);
      model_reset();
      @(posedge pClk);
      @(negedge pClk);
      rst_n = 1'b1;
      dut_pulses = 0;
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0);
         cycle();
      end
      chk("post_rst_pulses", 64'(dut_pulses), 64'd0);

      // Randomized traffic in phases of varying push and back-pressure density
      for (int ph = 0; ph < 15; ph++) begin
         p_v   = 20 + int'($urandom_range(80));
         p_alm = int'($urandom_range(95));
         for (int i = 0; i < 200; i++) begin
            drive(int'($urandom_range(99)) < p_v, int'($urandom_range(99)) < p_alm,
                  $urandom_range(199) == 0);
            cycle();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
